// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
//   Shared definitions for the four-source round-robin mux arbiter.
//   N_REQ       : number of requesters sharing the mux
//   SEL_W       : width of a source index / mux select
//   arb_state_t : arbiter FSM states (LOCK is reachable only with ARB_LOCK_EN)
//   onehot()    : source index -> one-hot request/grant vector
// -----------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // output register empty
    BUSY = 2'd1,  // output register holds a word
    LOCK = 2'd2   // burst in progress, only the locked source is eligible
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter_if
//   Bundles the four request ports and the registered valid/ready output stage.
//   Parameter DW : width of each source word and of out_data.
//   Signals:
//     req[3:0]        request per source, held with data stable until granted
//     in_data[4*DW]   source words, source i = in_data[i*DW +: DW]
//     in_last[3:0]    last beat of a burst per source (burst lock builds only)
//     gnt[3:0]        one-hot, combinational: source whose word is captured now
//     out_valid       out_data/out_sel hold a word
//     out_ready       consumer accepts the word when out_valid && out_ready
//     out_data[DW]    registered selected word
//     out_sel[1:0]    registered source index of out_data
//   Modports: slave = arbiter side, master = sources + consumer side.
// -----------------------------------------------------------------------------
interface mux4_rr_arbiter_if #(
  parameter int DW = 8
);
  import mux_arb_pkg::*;

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] in_data;
  logic [N_REQ-1:0]    in_last;
  logic [N_REQ-1:0]    gnt;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic [SEL_W-1:0]    out_sel;

  modport slave (
    input  req, in_data, in_last, out_ready,
    output gnt, out_valid, out_data, out_sel
  );

  modport master (
    output req, in_data, in_last, out_ready,
    input  gnt, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
//   Combinational rotating-priority picker. Priority runs ptr+1, ptr+2, ptr+3,
//   ptr+4 (mod 4), so the last winner ranks lowest.
//   Ports:
//     req[3:0]  in   eligible requests
//     ptr[1:0]  in   index of the previous winner
//     any       out  at least one request present
//     idx[1:0]  out  index of the winning source (0 when any=0)
// -----------------------------------------------------------------------------
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from lowest to highest priority; the last hit is the winner.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter sharing one 4:1 data mux between four requesters and
//   capturing the selected word into a registered valid/ready output stage.
//   Parameter DW : data width (default 8).
//   Ports:
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    mux4_rr_arbiter_if.slave (req/in_data/in_last/gnt/out_* signals)
//   Build option: define ARB_LOCK_EN to hold the grant on one source until it
//   presents a beat with in_last=1. Without it in_last is ignored and every
//   beat is re-arbitrated.
// -----------------------------------------------------------------------------
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mux4_rr_arbiter_if.slave        bus
);

  arb_state_t       state_q, state_d, enter_state;
  logic [SEL_W-1:0] rr_ptr;
  logic             out_valid_q;
  logic [DW-1:0]    out_data_q;
  logic [SEL_W-1:0] out_sel_q;

  logic             load, capture, pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] elig_req;

  // The output register can take a new word when empty or being drained.
  assign load = !out_valid_q || bus.out_ready;

`ifdef ARB_LOCK_EN
  // While locked, rr_ptr still names the burst owner.
  assign elig_req    = (state_q == LOCK) ? (bus.req & onehot(rr_ptr)) : bus.req;
  assign enter_state = bus.in_last[pick_idx] ? BUSY : LOCK;
`else
  assign elig_req    = bus.req;
  assign enter_state = BUSY;
`endif

  rr_pick4 u_pick (
    .req (elig_req),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign capture = load && pick_any;

  // Gated by rst_n so no grant leaks out while reset is held.
  assign bus.gnt       = (rst_n && capture) ? onehot(pick_idx) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (capture) state_d = enter_state;
      BUSY: begin
        if (capture)   state_d = enter_state;
        else if (load) state_d = IDLE;
      end
`ifdef ARB_LOCK_EN
      // An empty load while locked only drops out_valid; the lock persists.
      LOCK: if (capture) state_d = enter_state;
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr      <= 2'd3;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) out_valid_q <= capture;
      if (capture) begin
        out_data_q <= bus.in_data[int'(pick_idx)*DW +: DW];
        out_sel_q  <= pick_idx;
        rr_ptr     <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//   Directed bench for mux4_rr_arbiter. Inputs change on the falling edge;
//   gnt is sampled just after that, registered outputs 1 ns after the rising
//   edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mux4_rr_arbiter_if #(.DW(DW)) bus ();

  mux4_rr_arbiter #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Set inputs on the falling edge, then let gnt settle.
  task automatic drive(input logic [3:0] req, input logic ready, input logic [3:0] last);
    @(negedge clk);
    bus.req       = req;
    bus.out_ready = ready;
    bus.in_last   = last;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq_sel [4];

  initial begin
    rst_n         = 1'b0;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    bus.in_last   = 4'b1111;
    bus.in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_data", 32'(bus.out_data), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 2: granted same cycle, word out one cycle later.
    drive(4'b0100, 1'b1, 4'b1111);
    check("t2_gnt", 32'(bus.gnt), 32'h4);
    after_edge();
    check("t2_valid", 32'(bus.out_valid), 32'h1);
    check("t2_data", 32'(bus.out_data), 32'hA5);
    check("t2_sel", 32'(bus.out_sel), 32'h2);
    drive(4'b0000, 1'b1, 4'b1111);
    check("t2_drain_gnt", 32'(bus.gnt), 32'h0);
    after_edge();
    check("t2_drain_valid", 32'(bus.out_valid), 32'h0);
    check("t2_drain_sel", 32'(bus.out_sel), 32'h2);

    // Traffic, then async reset in the middle of a cycle.
    drive(4'b1111, 1'b1, 4'b1111);
    check("t1_pre_gnt", 32'(bus.gnt), 32'h8);
    after_edge();
    check("t1_pre_sel", 32'(bus.out_sel), 32'h3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_valid", 32'(bus.out_valid), 32'h0);
    check("t1_rst_gnt", 32'(bus.gnt), 32'h0);
    check("t1_rst_sel", 32'(bus.out_sel), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t1_rel_gnt", 32'(bus.gnt), 32'h1);

    // All four requesting: strict rotation starting from source 0.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) drive(4'b1111, 1'b1, 4'b1111);
      check($sformatf("t3_gnt%0d", i), 32'(bus.gnt), 32'(4'b0001 << (i % 4)));
      after_edge();
      check($sformatf("t3_sel%0d", i), 32'(bus.out_sel), 32'(i % 4));
      check($sformatf("t3_valid%0d", i), 32'(bus.out_valid), 32'h1);
    end
    check("t3_data", 32'(bus.out_data), 32'h11);

    // Backpressure with sources 0/1 waiting: nothing moves.
    for (int i = 0; i < 3; i++) begin
      drive(4'b0011, 1'b0, 4'b1111);
      check($sformatf("t4_gnt%0d", i), 32'(bus.gnt), 32'h0);
      after_edge();
      check($sformatf("t4_data%0d", i), 32'(bus.out_data), 32'h11);
      check($sformatf("t4_sel%0d", i), 32'(bus.out_sel), 32'h0);
    end
    // Release: transfer and next grant (source 1, after 0 won last) together.
    drive(4'b0011, 1'b1, 4'b1111);
    check("t4_rel_gnt", 32'(bus.gnt), 32'h2);
    after_edge();
    check("t4_rel_sel", 32'(bus.out_sel), 32'h1);
    check("t4_rel_data", 32'(bus.out_data), 32'h22);

    // Source 0 three-beat burst (last on beat 3) competing with source 1.
`ifdef ARB_LOCK_EN
    seq_sel = '{2'd0, 2'd0, 2'd0, 2'd1};
`else
    seq_sel = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(4'b0011, 1'b1, {3'b111, (i == 2)});
      check($sformatf("t5_gnt%0d", i), 32'(bus.gnt), 32'(onehot(seq_sel[i])));
      after_edge();
      check($sformatf("t5_sel%0d", i), 32'(bus.out_sel), 32'(seq_sel[i]));
    end

    // Source 3 requests under backpressure, then withdraws before a grant.
    for (int i = 0; i < 2; i++) begin
      drive(4'b1000, 1'b0, 4'b1111);
      check($sformatf("t6_hold_gnt%0d", i), 32'(bus.gnt), 32'h0);
      after_edge();
      check($sformatf("t6_hold_valid%0d", i), 32'(bus.out_valid), 32'h1);
    end
    drive(4'b0000, 1'b0, 4'b1111);
    check("t6_drop_gnt", 32'(bus.gnt), 32'h0);
    after_edge();
    check("t6_drop_valid", 32'(bus.out_valid), 32'h1);
    drive(4'b0000, 1'b1, 4'b1111);
    check("t6_xfer_gnt", 32'(bus.gnt), 32'h0);
    after_edge();
    check("t6_fall_valid", 32'(bus.out_valid), 32'h0);
    check("t6_sel_hold", 32'(bus.out_sel), 32'h1);
    check("t6_data_hold", 32'(bus.out_data), 32'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
